// File: rtl/fp_add_sub.sv
// Pipelined IEEE-754 binary32 adder/subtractor with fixed LAT-cycle latency.
// Stages: unpack/align, significand add, normalize, round, then LAT-4 delay registers.
module fp_add_sub #(
  parameter int LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        en,
  input  logic        sub,
  output logic [31:0] y
);
  // Issue protocol: en is a fire-and-forget strobe with no ready. The pipeline
  // never stalls, and each stage's valid bit follows the op it carries.
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam int          DLY  = LAT - 3;

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] cnt;
    cnt = 5'd0;
    for (int i = 0; i < 27; i++)
      if (v[i]) cnt = 5'(26 - i);
    return cnt;
  endfunction

  // ---------------- S1: unpack, classify, swap, align ----------------
  logic        sa, sb;
  logic [7:0]  ea, eb;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [23:0] ma, mb;
  logic        swap;
  logic [7:0]  el, es, ediff;
  logic [23:0] ml, ms;
  logic        sl, ss;
  logic [4:0]  shamt;
  logic [49:0] shifted;
  logic [26:0] al_small;
  logic        c_spec;
  logic [31:0] c_spec_val;

  always_comb begin
    sa     = a[31];
    sb     = b[31] ^ sub;
    ea     = a[30:23];
    eb     = b[30:23];
    a_nan  = (ea == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (eb == 8'hFF) && (b[22:0] != 23'd0);
    a_inf  = (ea == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (eb == 8'hFF) && (b[22:0] == 23'd0);
    // Subnormals carry exponent 0 and are treated as signed zero.
    a_zero = (ea == 8'd0);
    b_zero = (eb == 8'd0);
    ma     = a_zero ? 24'd0 : {1'b1, a[22:0]};
    mb     = b_zero ? 24'd0 : {1'b1, b[22:0]};
    swap   = {eb, mb} > {ea, ma};
    el     = swap ? eb : ea;
    es     = swap ? ea : eb;
    ml     = swap ? mb : ma;
    ms     = swap ? ma : mb;
    sl     = swap ? sb : sa;
    ss     = swap ? sa : sb;
    ediff  = el - es;
    // Shifts of 26 or more leave nothing above the sticky position.
    shamt    = (ediff > 8'd26) ? 5'd26 : ediff[4:0];
    shifted  = {ms, 26'd0} >> shamt;
    al_small = {shifted[49:24], |shifted[23:0]};

    c_spec     = 1'b1;
    c_spec_val = QNAN;
    if (a_nan || b_nan)                 c_spec_val = QNAN;
    else if (a_inf && b_inf && sa != sb) c_spec_val = QNAN;
    else if (a_inf)                     c_spec_val = {sa, 8'hFF, 23'd0};
    else if (b_inf)                     c_spec_val = {sb, 8'hFF, 23'd0};
    else if (a_zero && b_zero)          c_spec_val = {sa & sb, 31'd0};
    else                                c_spec     = 1'b0;
  end

  logic        v1, spec1, sign1, esub1;
  logic [31:0] specv1;
  logic [7:0]  exp1;
  logic [26:0] big1, small1;

  // ---------------- S2: significand add/subtract ----------------
  logic [27:0] sum_n;
  always_comb begin
    sum_n = esub1 ? ({1'b0, big1} - {1'b0, small1})
                  : ({1'b0, big1} + {1'b0, small1});
  end

  logic        v2, spec2, sign2;
  logic [31:0] specv2;
  logic [7:0]  exp2;
  logic [27:0] sum2;

  // ---------------- S3: normalize ----------------
  logic [4:0]  lz;
  logic [26:0] norm_n;
  logic [9:0]  exp_n;
  logic        zero_n;

  always_comb begin
    lz     = lzc27(sum2[26:0]);
    zero_n = (sum2 == 28'd0);
    if (sum2[27]) begin
      norm_n = {sum2[27:2], sum2[1] | sum2[0]};
      exp_n  = {2'b00, exp2} + 10'd1;
    end else begin
      norm_n = sum2[26:0] << lz;
      exp_n  = {2'b00, exp2} - {5'd0, lz};
    end
  end

  logic        v3, spec3, sign3, zero3;
  logic [31:0] specv3;
  logic [9:0]  exp3;
  logic [26:0] norm3;

  // ---------------- S4: round to nearest even, pack ----------------
  logic        rnd_up;
  logic [24:0] mant25;
  logic [9:0]  exp_r;
  logic [22:0] frac;
  logic [31:0] res_n;

  always_comb begin
    rnd_up = norm3[2] & (norm3[1] | norm3[0] | norm3[3]);
    mant25 = {1'b0, norm3[26:3]} + {24'd0, rnd_up};
    exp_r  = mant25[24] ? exp3 + 10'd1 : exp3;
    frac   = mant25[24] ? mant25[23:1] : mant25[22:0];
    // exp_r is two's complement; bit 9 set means the result underflowed.
    if (spec3)                                  res_n = specv3;
    else if (zero3 || exp_r[9] || exp_r == 10'd0) res_n = 32'd0;
    else if (exp_r >= 10'd255)                  res_n = {sign3, 8'hFF, 23'd0};
    else                                        res_n = {sign3, exp_r[7:0], frac};
  end

  logic        rv [DLY];
  logic [31:0] rd [DLY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0; spec1 <= 1'b0; sign1 <= 1'b0; esub1 <= 1'b0;
      specv1 <= 32'd0; exp1 <= 8'd0; big1 <= 27'd0; small1 <= 27'd0;
      v2 <= 1'b0; spec2 <= 1'b0; sign2 <= 1'b0;
      specv2 <= 32'd0; exp2 <= 8'd0; sum2 <= 28'd0;
      v3 <= 1'b0; spec3 <= 1'b0; sign3 <= 1'b0; zero3 <= 1'b0;
      specv3 <= 32'd0; exp3 <= 10'd0; norm3 <= 27'd0;
      for (int i = 0; i < DLY; i++) begin
        rv[i] <= 1'b0;
        rd[i] <= 32'd0;
      end
      y <= 32'd0;
    end else begin
      v1     <= en;
      spec1  <= c_spec;
      specv1 <= c_spec_val;
      sign1  <= sl;
      esub1  <= sl ^ ss;
      exp1   <= el;
      big1   <= {ml, 3'b000};
      small1 <= al_small;

      v2     <= v1;
      spec2  <= spec1;
      specv2 <= specv1;
      sign2  <= sign1;
      exp2   <= exp1;
      sum2   <= sum_n;

      v3     <= v2;
      spec3  <= spec2;
      specv3 <= specv2;
      sign3  <= sign2;
      zero3  <= zero_n;
      exp3   <= exp_n;
      norm3  <= norm_n;

      rv[0] <= v3;
      rd[0] <= res_n;
      for (int i = 1; i < DLY; i++) begin
        rv[i] <= rv[i-1];
        rd[i] <= rd[i-1];
      end
      if (rv[DLY-1]) y <= rd[DLY-1];
    end
  end

endmodule

// File: tb/tb_fp_add_sub.sv
// Bench for fp_add_sub: directed vectors plus random ops checked every cycle
// against an exact-integer reference and a positional latency model.
module tb_fp_add_sub;
  localparam int          LAT  = 4;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b;
  logic        en, sub;
  logic [31:0] y;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_y;
  logic [32:0] exp_q[$];

  fp_add_sub #(.LAT(LAT)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .en(en), .sub(sub), .y(y)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout y=%08h expected=finish", y);
    $fatal(1, "timeout");
  end

  // ---------------- reference model: exact integer sum, then RNE ----------------
  function automatic logic [31:0] ref_add(input logic [31:0] ra, input logic [31:0] rb_in,
                                          input logic rs_in);
    logic [31:0] rb;
    int          ea, eb, e_lo, p, sh, e_res;
    logic [63:0] va, vb, mag, q, rem, half;
    logic        sa, sb, rs;
    rb = {rb_in[31] ^ rs_in, rb_in[30:0]};
    sa = ra[31];
    sb = rb[31];
    ea = int'(ra[30:23]);
    eb = int'(rb[30:23]);
    if ((ea == 255 && ra[22:0] != 23'd0) || (eb == 255 && rb[22:0] != 23'd0)) return QNAN;
    if (ea == 255 && eb == 255) return (sa != sb) ? QNAN : ra;
    if (ea == 255) return ra;
    if (eb == 255) return rb;
    if (ea == 0 && eb == 0) return {sa & sb, 31'd0};
    if (ea == 0) return rb;
    if (eb == 0) return ra;
    if (ea - eb > 36) return ra;
    if (eb - ea > 36) return rb;
    e_lo = (ea < eb) ? ea : eb;
    va = {40'd0, 1'b1, ra[22:0]} << (ea - e_lo);
    vb = {40'd0, 1'b1, rb[22:0]} << (eb - e_lo);
    if (sa == sb)     begin mag = va + vb; rs = sa; end
    else if (va > vb) begin mag = va - vb; rs = sa; end
    else if (vb > va) begin mag = vb - va; rs = sb; end
    else return 32'd0;
    p = 0;
    for (int i = 0; i < 64; i++) if (mag[i]) p = i;
    e_res = e_lo + p - 23;
    if (p > 23) begin
      sh   = p - 23;
      q    = mag >> sh;
      rem  = mag & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 64'd1;
      if (q[24]) begin q = q >> 1; e_res = e_res + 1; end
    end else begin
      q = mag << (23 - p);
    end
    if (e_res >= 255) return {rs, 8'hFF, 23'd0};
    if (e_res <= 0) return 32'd0;
    return {rs, e_res[7:0], q[22:0]};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic model_flush();
    exp_q.delete();
    for (int i = 0; i < LAT; i++) exp_q.push_back(33'd0);
    exp_y = 32'd0;
  endtask

  task automatic check_y(input string tag);
    checks++;
    assert (y === exp_y) else begin
      failures++;
      $error("FAIL %s y=%08h expected=%08h", tag, y, exp_y);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic e, input logic [31:0] ta, input logic [31:0] tb,
                      input logic ts, input logic use_fixed, input logic [31:0] fixed,
                      input string tag);
    logic [32:0] ent;
    en  = e;
    a   = ta;
    b   = tb;
    sub = ts;
    @(posedge clk);
    #1;
    exp_q.push_back({e, use_fixed ? fixed : ref_add(ta, tb, ts)});
    ent = exp_q.pop_front();
    if (ent[32]) exp_y = ent[31:0];
    check_y(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, $urandom, $urandom, 1'b0, 1'b0, 32'd0, tag);
  endtask

  task automatic issue(input logic [31:0] ta, input logic [31:0] tb, input logic ts,
                       input logic [31:0] expv, input string tag);
    step(1'b1, ta, tb, ts, 1'b1, expv, tag);
  endtask

  function automatic logic [31:0] rand_op(input logic [31:0] other);
    logic [7:0] e;
    case ($urandom_range(0, 9))
      0: case ($urandom_range(0, 8))
           0: return 32'h0000_0000;
           1: return 32'h8000_0000;
           2: return 32'h7F80_0000;
           3: return 32'hFF80_0000;
           4: return 32'h7FC0_0000;
           5: return 32'h7F7F_FFFF;
           6: return 32'h0000_0001;
           7: return 32'h0080_0000;
           default: return 32'h7F80_0001;
         endcase
      1: return other;
      2: return {~other[31], other[30:0]};
      3, 4, 5: begin
        e = other[30:23] + 8'($urandom_range(0, 4)) - 8'd2;
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
      end
      6: return {1'($urandom_range(0, 1)), 8'($urandom_range(0, 3)), 23'($urandom)};
      default: return $urandom;
    endcase
  endfunction

  // ---------------- directed then random sequence ----------------
  initial begin
    logic [31:0] ra, rb;
    rst = 1'b1; en = 1'b0; a = 32'd0; b = 32'd0; sub = 1'b0;
    model_flush();
    repeat (2) @(posedge clk);
    #1;
    check_y("reset_state");
    #2 rst = 1'b0;

    // basic add: y stays 0 until LAT edges after issue
    issue(32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, "basic_add");
    idle(LAT, "basic_add_wait");

    issue(32'h3F00_0000, 32'h4000_0000, 1'b1, 32'hBFC0_0000, "sub_neg");
    issue(32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, "sub_cancel");
    idle(LAT, "sub_wait");

    // back-to-back then hold
    issue(32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, "b2b_1p1");
    issue(32'h4000_0000, 32'h4000_0000, 1'b0, 32'h4080_0000, "b2b_2p2");
    issue(32'h4040_0000, 32'h3F80_0000, 1'b1, 32'h4000_0000, "b2b_3m1");
    idle(LAT + 3, "b2b_hold");

    issue(32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, "rnd_tie_even");
    issue(32'h3F80_0000, 32'h3380_0001, 1'b0, 32'h3F80_0001, "rnd_above_half");
    issue(32'h3FFF_FFFF, 32'h3380_0000, 1'b0, 32'h4000_0000, "rnd_carry");
    issue(32'h7F80_0000, 32'hFF80_0000, 1'b0, 32'h7FC0_0000, "inf_minus_inf");
    issue(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, "overflow");
    issue(32'h0000_0001, 32'h0000_0000, 1'b0, 32'h0000_0000, "subnormal_flush");
    issue(32'h7FC0_0001, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, "nan_in");
    issue(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, "negzero_sum");
    issue(32'h0000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, "mixedzero_sum");
    issue(32'hFF80_0000, 32'h4120_0000, 1'b1, 32'hFF80_0000, "ninf_minus_fin");
    issue(32'h0080_0001, 32'h0080_0000, 1'b1, 32'h0000_0000, "underflow_flush");
    idle(LAT, "directed_drain");

    // reset mid-flight: asserted between edges, in-flight op must vanish
    issue(32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, "rst_flight_issue");
    idle(1, "rst_flight_gap");
    #2 rst = 1'b1;
    #1;
    model_flush();
    check_y("rst_async_clear");
    idle(2, "rst_held");
    #2 rst = 1'b0;
    idle(LAT + 2, "rst_no_ghost");

    // random ops against the reference model
    for (int n = 0; n < 400; n++) begin
      ra = rand_op($urandom);
      rb = rand_op(ra);
      step(1'($urandom_range(0, 4) != 0), ra, rb, 1'($urandom_range(0, 1)),
           1'b0, 32'd0, "random");
    end
    idle(LAT + 1, "random_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_add_sub.md
Name: fp_add_sub

Overview:
Pipelined IEEE-754 binary32 adder/subtractor with a fixed issue-to-result latency of LAT cycles, accepting one operation per cycle. Consumers such as the edge-function stepping logic in the fragment generator track issued operations by their own LAT-deep shift register and sample y exactly LAT cycles after issue. There is no output-valid strobe; timing is purely positional.

Parameters:
LAT, 4, issue-to-result latency in cycles (must be >= 4; cycles beyond 4 are pure delay registers after the round stage).

Ports:
clk  input  1  single clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-high; clears pipeline valid bits and y
a    input  32  operand A, binary32
b    input  32  operand B, binary32
en   input  1  issue strobe; a, b and sub are sampled on the rising edge where en=1
sub  input  1  0: y = a + b; 1: y = a - b (sign of b inverted before the add)
y    output  32  result register, binary32

Behaviour:
- Reset: asynchronous, active-high. While rst=1, y=0x00000000 and all pipeline valid bits are 0. Operations in flight when rst asserts are discarded and never appear on y.
- Pipeline: always advances, with no stall input. Each stage carries a valid bit loaded from en at issue.
- Nominal stages:
  - S1: unpack, classify, swap so |A| >= |B|, align the smaller significand with guard/round/sticky bits.
  - S2: add or subtract significands according to the effective sign.
  - S3: leading-zero count, normalize, exponent adjust.
  - S4: round to nearest, ties to even; handle overflow and specials.
  - Then LAT-4 delay registers.
- Timing: op issued at edge k (en=1) drives y after edge k+LAT, stable for that whole cycle. Back-to-back issues produce back-to-back results in issue order.
- Hold: y updates only when the final stage's valid bit is 1; otherwise y holds its previous value.
- en=0: inputs are ignored; no result is produced LAT cycles later.
- Arithmetic rules:
  - Subnormal inputs are flushed to signed zero.
  - Results below the minimum normal (2^-126) after rounding are flushed to +0.
  - Exact cancellation (x - x, x + -x) gives +0.
  - (+0)+(+0) = +0; (-0)+(-0) = -0; (+0)+(-0) = +0.
  - Overflow after rounding gives ±Inf (0x7F800000 / 0xFF800000).
  - Inf ± finite gives that Inf. +Inf + -Inf (effective) gives 0x7FC00000.
  - Any NaN operand gives canonical quiet NaN 0x7FC00000.
- Alignment: shift amounts >= 26 collapse the smaller operand into sticky only.
- Rounding carry-out renormalizes and increments the exponent.

Test Plan:
- Basic add: rst pulse; issue a=0x3F800000, b=0x40000000, sub=0 at edge k -> y=0x40400000 from edge k+LAT; y=0 before that.
- Subtract: issue 0x3F000000 - 0x40000000 -> y=0xBFC00000. Issue 0x3F800000 - 0x3F800000 -> y=0x00000000 (+0).
- Back-to-back: three consecutive cycles issuing 1+1, 2+2, 3-1 -> y shows 0x40000000, 0x40800000, 0x40000000 on consecutive cycles starting at k+LAT, then holds 0x40000000 while en=0.
- Rounding: 0x3F800000 + 0x33800000 (exact half-ulp tie) -> 0x3F800000. 0x3F800000 + 0x33800001 -> 0x3F800001. 0x3FFFFFFF + 0x33800000 -> 0x40000000.
- Specials: 0x7F800000 + 0xFF800000 -> 0x7FC00000. 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000. 0x00000001 + 0x00000000 -> 0x00000000. 0x7FC00001 + 0x3F800000 -> 0x7FC00000.
- Reset mid-flight: issue 1+2, assert rst two cycles later (asynchronously, between edges) -> y=0 immediately; after release, no result appears and y stays 0 until a new issue.
